rca_result_checker: RTL and testbench

Hardware response checker for the ripple-carry adder: it consumes operand/result vectors from the adder datapath over a valid/ready handshake and recomputes the expected sum a + b + cin for each one. It counts checked vectors and mismatches, captures the first failing vector, and reports pass/fail at the end of a session of programmed length. It sits downstream of the RCA and its stimulus source, replacing display-based checking with on-chip scoreboarding.

---
 rtl/rca_chk_if.sv | 21 ++
 rtl/rca_result_checker.sv | 161 ++++++++++++++++
 tb/tb_rca_result_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rca_chk_if.sv
// Vector handshake bundle between the RCA stimulus/datapath and rca_result_checker.
interface rca_chk_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH:0]   in_sum;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sum,
    output in_ready
  );
endinterface

// File: rtl/rca_result_checker.sv
// On-chip scoreboard for the ripple-carry adder: recomputes a+b+cin, counts mismatches,
// captures the first failing vector. Optional macro RCA_CHK_HALT_ON_ERR_EN stops the session at the first mismatch.
module rca_result_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vectors,
  rca_chk_if.slave          vin,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [WIDTH:0]    first_err_exp,
  output logic [WIDTH:0]    first_err_got
);

`ifdef RCA_CHK_HALT_ON_ERR_EN
  localparam bit HaltOnErr = 1'b1;
`else
  localparam bit HaltOnErr = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [WIDTH:0] rca_ref(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] chk_q, err_q;
  logic             fev_q;
  logic [CNT_W-1:0] fidx_q;
  logic [WIDTH:0]   fexp_q, fgot_q;

  // Stage register: one accepted vector waiting for its compare cycle
  logic             svld_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic             scin_q;
  logic [WIDTH:0]   ssum_q;
  logic [CNT_W-1:0] sidx_q;

  logic             in_ready_d;
  logic             xfer_d;
  logic [WIDTH:0]   exp_d;
  logic             mism_d;
  logic             last_d;
  logic             halt_d;
  logic [CNT_W-1:0] err_d;

  assign in_ready_d = (state_q == RUN) && (acc_q < num_q);
  assign xfer_d     = vin.in_valid && in_ready_d;
  assign exp_d      = rca_ref(sa_q, sb_q, scin_q);
  assign mism_d     = svld_q && (exp_d != ssum_q);
  assign last_d     = (sidx_q == num_q - CNT_W'(1));
  assign halt_d     = HaltOnErr && mism_d;
  assign err_d      = sat_inc(err_q);

  assign vin.in_ready = in_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      chk_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
      svld_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      scin_q  <= 1'b0;
      ssum_q  <= '0;
      sidx_q  <= '0;
    end else if (start) begin
      // A new session overrides any same-cycle transfer or commit
      num_q  <= num_vectors;
      acc_q  <= '0;
      chk_q  <= '0;
      err_q  <= '0;
      fev_q  <= 1'b0;
      fidx_q <= '0;
      fexp_q <= '0;
      fgot_q <= '0;
      svld_q <= 1'b0;
      if (num_vectors == '0) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= 1'b1;
      end else begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
      end
    end else begin
      svld_q <= 1'b0;
      if (state_q == RUN) begin
        if (xfer_d && !halt_d) begin
          svld_q <= 1'b1;
          sa_q   <= vin.in_a;
          sb_q   <= vin.in_b;
          scin_q <= vin.in_cin;
          ssum_q <= vin.in_sum;
          sidx_q <= acc_q;
          acc_q  <= acc_q + CNT_W'(1);
        end
        if (svld_q) begin
          chk_q <= chk_q + CNT_W'(1);
          if (mism_d) begin
            err_q <= err_d;
            if (!fev_q) begin
              fev_q  <= 1'b1;
              fidx_q <= sidx_q;
              fexp_q <= exp_d;
              fgot_q <= ssum_q;
            end
          end
          if (last_d || halt_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mism_d && (err_q == '0);
          end
        end
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign chk_cnt         = chk_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fidx_q;
  assign first_err_exp   = fexp_q;
  assign first_err_got   = fgot_q;

endmodule

// File: tb/tb_rca_result_checker.sv
// Randomized scoreboard bench for rca_result_checker: driver pushes per-session expectations, monitor checks at done.
module tb_rca_result_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             busy, done, pass, first_err_valid;
  logic [CNT_W-1:0] chk_cnt, err_cnt, first_err_idx;
  logic [WIDTH:0]   first_err_exp, first_err_got;

  rca_chk_if #(.WIDTH(WIDTH)) bus ();

  rca_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors), .vin(bus.slave),
    .busy(busy), .done(done), .pass(pass), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int chk; int err; int fev; int fidx; int fexp; int fgot; int pass;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every rising edge of done closes one session
  initial begin
    bit   dprev;
    exp_t e;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dprev) begin
        if (sbq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          check("chk_cnt", chk_cnt, e.chk);
          check("err_cnt", err_cnt, e.err);
          check("first_err_valid", first_err_valid, e.fev);
          check("first_err_idx", first_err_idx, e.fidx);
          check("first_err_exp", first_err_exp, e.fexp);
          check("first_err_got", first_err_got, e.fgot);
          check("pass", pass, e.pass);
        end
      end
      dprev = done;
    end
  end

  task automatic pulse_start(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds n vectors at full rate; vector 0 optionally carries a wrong sum
  task automatic feed_raw(input int n, input bit bad_first);
    int a, b, c;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
      bus.in_a = 4'(a); bus.in_b = 4'(b); bus.in_cin = c[0];
      bus.in_sum = 5'(a + b + c + ((bad_first && i == 0) ? 1 : 0));
      bus.in_valid = 1'b1;
      if (!bus.in_ready) check("raw_ready", 0, 1);
      @(negedge clk);
    end
  endtask

  task automatic run_session(input int n, input int err_idx, input bit gaps,
                             input bit bounds, input bit timing, input bit rnd_err);
    int     va[64], vb[64], vc[64], vs[64];
    exp_t   e;
    int     s, to;
    bit     stopm, stop;
    longint acc0;
    for (int i = 0; i < n; i++) begin
      va[i] = $urandom_range(0, 15); vb[i] = $urandom_range(0, 15); vc[i] = $urandom_range(0, 1);
      if (bounds && i == 0) begin va[i] = 15; vb[i] = 15; vc[i] = 1; end
      if (bounds && i == 1) begin va[i] = 0;  vb[i] = 0;  vc[i] = 0; end
      vs[i] = va[i] + vb[i] + vc[i];
      if (rnd_err && $urandom_range(0, 7) == 0) vs[i] = (vs[i] ^ $urandom_range(1, 31)) & 31;
      if (i == err_idx) begin va[i] = 9; vb[i] = 8; vc[i] = 1; vs[i] = 17; end
    end
    e = '{0, 0, 0, 0, 0, 0, 0};
    stopm = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!stopm) begin
        s = va[i] + vb[i] + vc[i];
        e.chk++;
        if (s != vs[i]) begin
          if (e.err < 65535) e.err++;
          if (e.fev == 0) begin e.fev = 1; e.fidx = i; e.fexp = s; e.fgot = vs[i]; end
`ifdef RCA_CHK_HALT_ON_ERR_EN
          stopm = 1'b1;
`endif
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    sbq.push_back(e);

    pulse_start(n);
    check("start_clears_chk", chk_cnt, 0);
    check("start_clears_fev", first_err_valid, 0);
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_ready", bus.in_ready, 0);
    end else check("busy_in_run", busy, 1);

    stop = 1'b0;
    acc0 = 0;
    for (int i = 0; i < n && !stop; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_a = 4'(va[i]); bus.in_b = 4'(vb[i]); bus.in_cin = vc[i][0]; bus.in_sum = 5'(vs[i]);
      bus.in_valid = 1'b1;
      to = 0;
      while (!bus.in_ready && !done && to < 50) begin @(negedge clk); to++; end
      if (done) stop = 1'b1;
      else if (!bus.in_ready) begin check("accept_timeout", 0, 1); stop = 1'b1; end
      else begin
        if (i == 0) acc0 = cyc + 1;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    if (timing) check("ready_low_after_last", bus.in_ready, 0);
    to = 0;
    while (!done && to < 20) begin @(negedge clk); to++; end
    check("done_reached", done, 1);
    if (timing) check("done_latency", cyc - acc0, n);
    @(negedge clk);
  endtask

  initial begin
    int hi;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sum = '0;
    #3;
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_chk", chk_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fev", first_err_valid, 0);
    check("rst_fidx", first_err_idx, 0);
    check("rst_fexp", first_err_exp, 0);
    check("rst_fgot", first_err_got, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_session(20, -1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_session(20, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_session(12, -1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) run_session($urandom_range(1, 30), -1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-session, with a captured error and a vector in the stage
    pulse_start(10);
    feed_raw(3, 1'b1);
    check("pre_reset_fev", first_err_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", bus.in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_chk", chk_cnt, 0);
    check("arst_err", err_cnt, 0);
    check("arst_fev", first_err_valid, 0);
    check("arst_fidx", first_err_idx, 0);
    check("arst_fgot", first_err_got, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    hi = 0;
    repeat (5) begin @(negedge clk); if (bus.in_ready) hi++; end
    bus.in_valid = 1'b0;
    check("idle_ready_never", hi, 0);
    check("idle_chk", chk_cnt, 0);

    run_session(0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart in the middle of a session
    pulse_start(8);
    feed_raw(3, 1'b1);
    run_session(10, -1, 1'b1, 1'b0, 1'b0, 1'b1);

    hi = 0;
    while (sbq.size() != 0 && hi < 50) begin @(negedge clk); hi++; end
    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
